// File: rtl/dmem_dma_master.sv
// Block copy / block fill initiator for the data memory port.
// mem_busy marks port ownership; done pulses once per accepted command.
module dmem_dma_master #(
    parameter int Width     = 32,
    parameter int Depth     = 128,
    parameter int AD_Width  = 32,
    parameter int LEN_Width = 8
) (
    input  logic                 clk,
    input  logic                 Res,
    input  logic                 start,
    input  logic                 mode,
    input  logic [AD_Width-1:0]  src_addr,
    input  logic [AD_Width-1:0]  dst_addr,
    input  logic [LEN_Width-1:0] len,
    input  logic [Width-1:0]     fill_value,
    input  logic [Width-1:0]     RData,
    output logic [AD_Width-1:0]  Address,
    output logic [Width-1:0]     WData,
    output logic                 Wr_En,
    output logic                 mem_busy,
    output logic                 done,
    output logic                 err,
    output logic [LEN_Width-1:0] word_count,
    output logic [Width-1:0]     checksum
);

    typedef enum logic [2:0] {IDLE, RD, WR, FILL, FIN} state_t;

    localparam logic [AD_Width:0]   DEPTH_X = (AD_Width+1)'(Depth);
    localparam logic [AD_Width-1:0] ONE_AD  = 1;

    state_t               state_q, state_d;
    logic [AD_Width-1:0]  src_ptr, dst_ptr;
    logic [Width-1:0]     data_reg, fill_reg;
    logic [LEN_Width-1:0] len_reg;
    logic                 err_reg;

    logic [AD_Width:0]    src_end, dst_end;
    logic                 range_err;
    logic [LEN_Width:0]   wc_next;
    logic                 last_word;

    // End addresses are formed one bit wider so the check cannot wrap.
    assign src_end   = {1'b0, src_addr} + (AD_Width+1)'(len);
    assign dst_end   = {1'b0, dst_addr} + (AD_Width+1)'(len);
    assign range_err = (dst_end > DEPTH_X) || (!mode && (src_end > DEPTH_X));
    assign wc_next   = {1'b0, word_count} + {{LEN_Width{1'b0}}, 1'b1};
    assign last_word = (wc_next == {1'b0, len_reg});

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (range_err || (len == '0)) state_d = FIN;
                    else if (mode)                state_d = FILL;
                    else                          state_d = RD;
                end
            end
            RD:      state_d = WR;
            WR:      state_d = last_word ? FIN : RD;
            FILL:    state_d = last_word ? FIN : FILL;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Address  = '0;
        WData    = '0;
        Wr_En    = 1'b0;
        mem_busy = (state_q != IDLE);
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            RD: Address = src_ptr;
            WR: begin
                Address = dst_ptr;
                WData   = data_reg;
                Wr_En   = 1'b1;
            end
            FILL: begin
                Address = dst_ptr;
                WData   = fill_reg;
                Wr_En   = 1'b1;
            end
            FIN: begin
                done = 1'b1;
                err  = err_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Res) begin
            state_q    <= IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            data_reg   <= '0;
            fill_reg   <= '0;
            len_reg    <= '0;
            err_reg    <= 1'b0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_ptr    <= src_addr;
                        dst_ptr    <= dst_addr;
                        len_reg    <= len;
                        fill_reg   <= fill_value;
                        err_reg    <= range_err;
                        word_count <= '0;
                        checksum   <= '0;
                    end
                end
                RD: begin
                    data_reg <= RData;
                    src_ptr  <= src_ptr + ONE_AD;
                end
                WR: begin
                    dst_ptr    <= dst_ptr + ONE_AD;
                    word_count <= wc_next[LEN_Width-1:0];
                    checksum   <= checksum + data_reg;
                end
                FILL: begin
                    dst_ptr    <= dst_ptr + ONE_AD;
                    word_count <= wc_next[LEN_Width-1:0];
                    checksum   <= checksum + fill_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_dma_master.sv
// Directed bench for dmem_dma_master with a behavioural 128-word data memory.
module tb_dmem_dma_master;

    localparam int W  = 32;
    localparam int D  = 128;
    localparam int AW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          res;
    logic          start;
    logic          mode;
    logic [AW-1:0] src_addr, dst_addr;
    logic [LW-1:0] len;
    logic [W-1:0]  fill_value;
    logic [W-1:0]  rdata;
    logic [AW-1:0] address;
    logic [W-1:0]  wdata;
    logic          wr_en, mem_busy, done, err;
    logic [LW-1:0] word_count;
    logic [W-1:0]  checksum;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_dma_master #(.Width(W), .Depth(D), .AD_Width(AW), .LEN_Width(LW)) dut (
        .clk        (clk),
        .Res        (res),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .fill_value (fill_value),
        .RData      (rdata),
        .Address    (address),
        .WData      (wdata),
        .Wr_En      (wr_en),
        .mem_busy   (mem_busy),
        .done       (done),
        .err        (err),
        .word_count (word_count),
        .checksum   (checksum)
    );

    // Memory model: combinational read, write on rising edge; bench preload port.
    logic [W-1:0] mem [0:D-1];
    logic         pl_en = 1'b0;
    logic [6:0]   pl_addr = '0;
    logic [W-1:0] pl_data = '0;
    int           wr_total = 0;

    assign rdata = (address < AW'(D)) ? mem[address[6:0]] : '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (wr_en) begin
            if (address < AW'(D)) mem[address[6:0]] <= wdata;
            wr_total <= wr_total + 1;
        end
    end

    logic [AW-1:0] addr_tr [1:64];
    logic          we_tr   [1:64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int a, input logic [W-1:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = 7'(a);
        pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Issues one command and follows it to done; cycle 1 is the cycle after the start edge.
    task automatic run_cmd(input logic m, input int s, input int dd, input int n,
                           input logic [W-1:0] fv, output int done_cyc, output logic err_seen);
        done_cyc = 0;
        err_seen = 1'b0;
        @(negedge clk);
        mode       = m;
        src_addr   = AW'(s);
        dst_addr   = AW'(dd);
        len        = LW'(n);
        fill_value = fv;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            addr_tr[c] = address;
            we_tr[c]   = wr_en;
            if (done) begin
                done_cyc = c;
                err_seen = err;
                break;
            end
        end
        if (done_cyc == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_addr"},  address,    32'd0);
        chk({tag, "_wdata"}, wdata,      32'd0);
        chk({tag, "_wren"},  32'(wr_en),    32'd0);
        chk({tag, "_busy"},  32'(mem_busy), 32'd0);
        chk({tag, "_done"},  32'(done),     32'd0);
        chk({tag, "_err"},   32'(err),      32'd0);
        chk({tag, "_wc"},    32'(word_count), 32'd0);
        chk({tag, "_cs"},    checksum,   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dc;
        logic es;
        int   w0;
        logic [AW-1:0] copy_addr [0:5];
        copy_addr = '{32'd0, 32'd20, 32'd1, 32'd21, 32'd2, 32'd22};

        res = 1'b1; start = 1'b0; mode = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0; fill_value = '0;
        for (int i = 0; i < D; i++) preload(i, 32'hDEAD_0000 + 32'(i));
        @(negedge clk);
        chk_idle_outputs("reset");
        res = 1'b0;

        // Fill 4 words at 10..13
        w0 = wr_total;
        run_cmd(1'b1, 0, 10, 4, 32'hA5A5_0001, dc, es);
        chk("fill_done_cyc", 32'(dc), 32'd5);
        chk("fill_err", 32'(es), 32'd0);
        chk("fill_wc", 32'(word_count), 32'd4);
        chk("fill_cs", checksum, 32'h9694_0004);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("fill_addr%0d", c), addr_tr[c], 32'(9 + c));
            chk($sformatf("fill_we%0d", c), 32'(we_tr[c]), 32'd1);
            chk($sformatf("fill_mem%0d", 9 + c), mem[9 + c], 32'hA5A5_0001);
        end
        chk("fill_mem14", mem[14], 32'hDEAD_000E);
        chk("fill_writes", 32'(wr_total - w0), 32'd4);

        // Copy 0..2 -> 20..22
        preload(0, 32'd1); preload(1, 32'd2); preload(2, 32'd3);
        run_cmd(1'b0, 0, 20, 3, 32'hFFFF_FFFF, dc, es);
        chk("copy_done_cyc", 32'(dc), 32'd7);
        chk("copy_wc", 32'(word_count), 32'd3);
        chk("copy_cs", checksum, 32'd6);
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("copy_addr%0d", c), addr_tr[c], copy_addr[c-1]);
            chk($sformatf("copy_we%0d", c), 32'(we_tr[c]), 32'(c % 2 == 0));
        end
        for (int i = 0; i < 3; i++) chk($sformatf("copy_mem%0d", 20 + i), mem[20 + i], 32'(i + 1));
        chk("copy_mem23", mem[23], 32'hDEAD_0017);

        // len = 0 clears the previous count and completes immediately
        run_cmd(1'b1, 0, 5, 0, 32'h1234_5678, dc, es);
        chk("len0_done_cyc", 32'(dc), 32'd1);
        chk("len0_err", 32'(es), 32'd0);
        chk("len0_wc", 32'(word_count), 32'd0);
        chk("len0_cs", checksum, 32'd0);

        // dst 126 + 3 runs past the end
        w0 = wr_total;
        run_cmd(1'b0, 0, 126, 3, 32'd0, dc, es);
        chk("rerr_done_cyc", 32'(dc), 32'd1);
        chk("rerr_err", 32'(es), 32'd1);
        chk("rerr_writes", 32'(wr_total - w0), 32'd0);
        // dst 125 + 3 ends exactly at Depth and is legal
        run_cmd(1'b1, 0, 125, 3, 32'h0000_0100, dc, es);
        chk("edge_done_cyc", 32'(dc), 32'd4);
        chk("edge_err", 32'(es), 32'd0);
        chk("edge_mem127", mem[127], 32'h0000_0100);
        // copy source overrun in copy mode
        run_cmd(1'b0, 127, 0, 2, 32'd0, dc, es);
        chk("srcerr_err", 32'(es), 32'd1);

        // Overlapping copy with dst > src replicates the first word
        preload(0, 32'd7); preload(1, 32'd8); preload(2, 32'd9); preload(3, 32'd10);
        run_cmd(1'b0, 0, 1, 3, 32'd0, dc, es);
        for (int i = 0; i < 4; i++) chk($sformatf("ovl_mem%0d", i), mem[i], 32'd7);
        chk("ovl_cs", checksum, 32'd21);

        // Reset during a fill of 8, with a start pulse while busy
        w0 = wr_total;
        @(negedge clk);
        mode = 1'b1; dst_addr = 32'd40; len = 8'd8; fill_value = 32'h55AA_0000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mode = 1'b1; dst_addr = 32'd60; len = 8'd1; fill_value = 32'h0BAD_0BAD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_busy_addr", address, 32'd42);
        chk("rst_busy", 32'(mem_busy), 32'd1);
        res = 1'b1;
        @(negedge clk);
        chk_idle_outputs("abort");
        res = 1'b0;
        @(negedge clk);
        chk("abort_writes", 32'(wr_total - w0), 32'd3);
        for (int i = 40; i < 43; i++) chk($sformatf("abort_mem%0d", i), mem[i], 32'h55AA_0000);
        chk("abort_mem43", mem[43], 32'hDEAD_002B);
        chk("abort_mem60", mem[60], 32'hDEAD_003C);

        // Back-to-back: start held in FIN is ignored, taken one cycle later
        @(negedge clk);
        mode = 1'b1; dst_addr = 32'd50; len = 8'd2; fill_value = 32'h1111_2222; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_first_done", 32'(done), 32'd1);
        chk("b2b_first_cs", checksum, 32'h2222_4444);
        mode = 1'b1; dst_addr = 32'd70; len = 8'd1; fill_value = 32'h3333_4444; start = 1'b1;
        @(negedge clk);
        chk("b2b_fin_ignored", 32'(mem_busy), 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_second_addr", address, 32'd70);
        chk("b2b_second_we", 32'(wr_en), 32'd1);
        @(negedge clk);
        chk("b2b_second_done", 32'(done), 32'd1);
        chk("b2b_second_err", 32'(err), 32'd0);
        chk("b2b_second_wc", 32'(word_count), 32'd1);
        chk("b2b_second_cs", checksum, 32'h3333_4444);
        chk("b2b_mem50", mem[50], 32'h1111_2222);
        chk("b2b_mem51", mem[51], 32'h1111_2222);
        chk("b2b_mem70", mem[70], 32'h3333_4444);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
